// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit and its store.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} fetch_state_t;

  // Index width for a store of the given depth (never less than one bit).
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned clamp_pc(input int unsigned target, input int unsigned depth);
    return (target >= depth) ? depth - 1 : target;
  endfunction

endpackage

// File: rtl/inst_store.sv
// DEPTH x IW instruction store: synchronous write, combinational read.
module inst_store
  import fetch_pkg::*;
#(
  parameter int unsigned IW    = 16,
  parameter int unsigned DEPTH = 24,
  parameter int unsigned AW    = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch on purpose: program contents must
  // survive a core reset, and a reset port would stop RAM inference.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the store and presents
// registered instructions to decode over a valid/ready handshake.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned IW         = 16,
  parameter int unsigned DEPTH      = 24,
  parameter int unsigned PCW        = 13,
  parameter bit          CLAMP_LAST = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_we,
  input  logic [PCW-1:0] load_addr,
  input  logic [IW-1:0]  load_data,
  output logic           load_err,
  input  logic           start,
  input  logic           branch_valid,
  input  logic [PCW-1:0] branch_target,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [IW-1:0]  out_instr,
  output logic [PCW-1:0] out_pc,
  output logic           busy,
  output logic           done
);

  localparam int unsigned    AW      = addr_width(DEPTH);
  localparam logic [PCW-1:0] LAST_PC = PCW'(DEPTH - 1);

  fetch_state_t   state, state_n;
  logic [PCW-1:0] pc, pc_n;
  logic           out_valid_n;
  logic [IW-1:0]  out_instr_n;
  logic [PCW-1:0] out_pc_n;
  logic           load_err_n;
  logic           advance;
  logic           store_we;
  logic [IW-1:0]  rd_data;

  assign advance  = ~out_valid | out_ready;
  // Loading is only legal while the PC is parked, and only in range.
  assign store_we = load_we & ((state == IDLE) || (state == DONE)) & (load_addr <= LAST_PC);

  inst_store #(.IW(IW), .DEPTH(DEPTH)) u_store (
    .clk   (clk),
    .we    (store_we),
    .waddr (load_addr[AW-1:0]),
    .wdata (load_data),
    .raddr (pc[AW-1:0]),
    .rdata (rd_data)
  );

  always_comb begin
    // NOTE: every target gets a hold value first so no path infers a latch.
    state_n     = state;
    pc_n        = pc;
    out_valid_n = out_valid;
    out_instr_n = out_instr;
    out_pc_n    = out_pc;
    load_err_n  = load_we & ~store_we;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = FETCH;
          pc_n    = '0;
        end
      end
      FETCH, DRAIN: begin
        if (branch_valid) begin
          // Flush the presented word; a same-cycle fire has already been taken.
          out_valid_n = 1'b0;
          pc_n        = PCW'(clamp_pc(32'(branch_target), DEPTH));
          state_n     = FETCH;
        end else if (state == FETCH) begin
          if (advance) begin
            out_instr_n = rd_data;
            out_pc_n    = pc;
            out_valid_n = 1'b1;
            if (pc != LAST_PC)   pc_n    = pc + PCW'(1);
            else if (!CLAMP_LAST) state_n = DRAIN;
          end
        end else if (advance) begin
          out_valid_n = 1'b0;
          state_n     = DONE;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      out_valid <= out_valid_n;
      out_instr <= out_instr_n;
      out_pc    <= out_pc_n;
      load_err  <= load_err_n;
    end
  end

  assign busy = (state == FETCH) || (state == DRAIN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: a clamping and a non-clamping
// instance share stimulus; vector table, hand sequences and a random stream.
module tb_inst_fetch_unit;

  localparam int DEPTH = 24;

  logic        clk = 1'b0;
  logic        reset, load_we, start, branch_valid, out_ready;
  logic [12:0] load_addr, branch_target;
  logic [15:0] load_data;

  logic        c_load_err, c_out_valid, c_busy, c_done;
  logic [15:0] c_out_instr;
  logic [12:0] c_out_pc;
  logic        n_load_err, n_out_valid, n_busy, n_done;
  logic [15:0] n_out_instr;
  logic [12:0] n_out_pc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  inst_fetch_unit #(.IW(16), .DEPTH(DEPTH), .PCW(13), .CLAMP_LAST(1'b1)) u_dut_clamp (
    .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .load_err(c_load_err), .start(start), .branch_valid(branch_valid), .branch_target(branch_target),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_instr(c_out_instr), .out_pc(c_out_pc),
    .busy(c_busy), .done(c_done)
  );

  inst_fetch_unit #(.IW(16), .DEPTH(DEPTH), .PCW(13), .CLAMP_LAST(1'b0)) u_dut_stop (
    .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .load_err(n_load_err), .start(start), .branch_valid(branch_valid), .branch_target(branch_target),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_instr(n_out_instr), .out_pc(n_out_pc),
    .busy(n_busy), .done(n_done)
  );

  typedef struct {
    logic        rst, we;
    logic [12:0] addr;
    logic [15:0] data;
    logic        st, br;
    logic [12:0] tgt;
    logic        rdy;
    logic        e_valid;
    logic [12:0] e_pc;
    logic [15:0] e_instr;
    logic        e_err, e_busy, e_done;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(int rst, int we, int addr, int data, int st, int br, int tgt,
                             int rdy, int ev, int epc, int ei, int eerr, int ebusy, int edone);
    vec_t r;
    r.rst = 1'(rst);  r.we = 1'(we);   r.addr = 13'(addr); r.data = 16'(data);
    r.st  = 1'(st);   r.br = 1'(br);   r.tgt  = 13'(tgt);  r.rdy  = 1'(rdy);
    r.e_valid = 1'(ev); r.e_pc = 13'(epc); r.e_instr = 16'(ei);
    r.e_err = 1'(eerr); r.e_busy = 1'(ebusy); r.e_done = 1'(edone);
    return r;
  endfunction

  // Plain accepted fetch of pc k from the default program.
  function automatic vec_t rd(int k);
    return v(0, 0, 0, 0, 0, 0, 0, 1, 1, k, 'hA000 + k, 0, 1, 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    reset = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; branch_valid = 1'b0; branch_target = '0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_program(input bit random_data);
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = random_data ? 16'($urandom) : 16'(16'hA000 + i);
      load_we = 1'b1; load_addr = 13'(i); load_data = model_mem[i];
      tick();
    end
    load_we = 1'b0;
  endtask

  initial begin
    int exp_pc;
    bit prev_stall, prev_we;
    logic [12:0] hold_pc;
    logic [15:0] hold_instr;

    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset valid", 32'(c_out_valid), 0);
    check("reset instr", 32'(c_out_instr), 0);
    check("reset pc",    32'(c_out_pc),    0);
    check("reset err",   32'(c_load_err),  0);
    check("reset busy",  32'(c_busy),      0);
    check("reset done",  32'(c_done),      0);

    load_program(1'b0);

    // ---------------- vector table on the clamping instance ----------------
    vq.push_back(v(0, 1, 30, 'hFFFF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k <= 5; k++) vq.push_back(rd(k));
    for (int k = 0; k < 3; k++) vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 'hA005, 0, 1, 0));
    for (int k = 6; k <= 10; k++) vq.push_back(rd(k));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 1, 0));
    vq.push_back(rd(2));
    vq.push_back(rd(3));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 40, 1, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 3; k++) vq.push_back(rd(23));
    vq.push_back(v(0, 1, 3, 'hDEAD, 0, 0, 0, 1, 1, 23, 'hA017, 1, 1, 0));
    vq.push_back(rd(23));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0, 1, 0));
    for (int k = 3; k <= 7; k++) vq.push_back(rd(k));
    vq.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(rd(0));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, 0, 1, 0));
    vq.push_back(rd(7));
    vq.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 1, 0, 'h1234, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'h1234, 0, 1, 0));
    vq.push_back(rd(1));
    vq.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst; load_we = vq[i].we; load_addr = vq[i].addr; load_data = vq[i].data;
      start = vq[i].st; branch_valid = vq[i].br; branch_target = vq[i].tgt; out_ready = vq[i].rdy;
      tick();
      check($sformatf("vec%0d valid", i), 32'(c_out_valid), 32'(vq[i].e_valid));
      check($sformatf("vec%0d err", i),   32'(c_load_err),  32'(vq[i].e_err));
      check($sformatf("vec%0d busy", i),  32'(c_busy),      32'(vq[i].e_busy));
      check($sformatf("vec%0d done", i),  32'(c_done),      32'(vq[i].e_done));
      if (vq[i].e_valid) begin
        check($sformatf("vec%0d pc", i),    32'(c_out_pc),    32'(vq[i].e_pc));
        check($sformatf("vec%0d instr", i), 32'(c_out_instr), 32'(vq[i].e_instr));
      end
    end

    // ------------- full run: stop-at-end vs clamp-on-last ------------------
    do_reset();
    load_program(1'b0);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      check($sformatf("run%0d stop valid", k), 32'(n_out_valid), 1);
      check($sformatf("run%0d stop pc", k),    32'(n_out_pc),    32'(k));
      check($sformatf("run%0d stop instr", k), 32'(n_out_instr), 32'(16'hA000 + k));
      check($sformatf("run%0d clamp pc", k),   32'(c_out_pc),    32'(k));
    end
    check("stop last busy", 32'(n_busy), 1);
    tick();
    check("stop end valid", 32'(n_out_valid), 0);
    check("stop end done",  32'(n_done),      1);
    check("stop end busy",  32'(n_busy),      0);
    check("clamp repeat valid", 32'(c_out_valid), 1);
    check("clamp repeat pc",    32'(c_out_pc),    23);
    check("clamp repeat instr", 32'(c_out_instr), 32'h0000A017);
    tick();
    check("clamp repeat2 pc", 32'(c_out_pc), 23);
    check("stop hold done",   32'(n_done),   1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart busy",  32'(n_busy),      1);
    check("restart done",  32'(n_done),      0);
    check("restart valid", 32'(n_out_valid), 0);
    tick();
    check("restart pc",    32'(n_out_pc),    0);
    check("restart instr", 32'(n_out_instr), 32'h0000A000);

    // ---------------- random stream against an ordering model --------------
    do_reset();
    load_program(1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_pc = 0;
    prev_stall = 1'b0;
    prev_we = 1'b0;
    hold_pc = '0;
    hold_instr = '0;
    for (int c = 0; c < 600; c++) begin
      out_ready     = ($urandom_range(0, 9) < 7);
      branch_valid  = ($urandom_range(0, 19) == 0);
      branch_target = 13'($urandom_range(0, 40));
      load_we       = ($urandom_range(0, 15) == 0);
      load_addr     = 13'($urandom_range(0, DEPTH - 1));
      load_data     = 16'($urandom);

      check("rand err", 32'(c_load_err), 32'(prev_we));
      if (prev_stall) begin
        check("rand stall valid", 32'(c_out_valid), 1);
        check("rand stall pc",    32'(c_out_pc),    32'(hold_pc));
        check("rand stall instr", 32'(c_out_instr), 32'(hold_instr));
      end
      if (c_out_valid && out_ready) begin
        check("rand pc",    32'(c_out_pc),    32'(exp_pc));
        check("rand instr", 32'(c_out_instr), 32'(model_mem[exp_pc]));
        exp_pc = (exp_pc < DEPTH - 1) ? exp_pc + 1 : DEPTH - 1;
      end
      if (branch_valid) exp_pc = (int'(branch_target) >= DEPTH) ? DEPTH - 1 : int'(branch_target);
      prev_stall = c_out_valid & ~out_ready & ~branch_valid;
      hold_pc    = c_out_pc;
      hold_instr = c_out_instr;
      prev_we    = load_we;
      tick();
    end

    drive_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Parametrised successor to the flat, combinationally indexed instruction ROM. It holds a DEPTH x IW instruction store that is loaded word by word through a write port. It owns its own PC and presents registered instructions to the decode stage over a valid/ready handshake, with branch redirect, end-of-program handling and a selectable clamp-on-last-instruction mode. It sits between the program loader and the decoder in the single-cycle/multicycle core.

Parameters:
IW, 16, instruction width in bits
DEPTH, 24, number of instruction words
PCW, 13, PC width (must satisfy 2**PCW >= DEPTH)
CLAMP_LAST, 1, 1 = repeat last word forever after reaching DEPTH-1; 0 = stop and report done

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
load_we  in  1  write strobe for instruction store
load_addr  in  PCW  write address
load_data  in  IW  write data
load_err  out  1  one-cycle pulse: write rejected
start  in  1  begin fetching from PC 0
branch_valid  in  1  redirect request
branch_target  in  PCW  redirect PC
out_valid  out  1  out_instr/out_pc valid
out_ready  in  1  decoder accepts this cycle
out_instr  out  IW  fetched instruction
out_pc  out  PCW  PC of out_instr
busy  out  1  state is FETCH or DRAIN
done  out  1  state is DONE

Behaviour:
- Reset (sync, active-high): state IDLE; pc=0; out_valid=0, out_instr=0, out_pc=0, load_err=0, busy=0, done=0. Instruction store contents are not cleared.
- Definitions: fire = out_valid & out_ready; advance = ~out_valid | out_ready.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE/DONE:
  - load_we with load_addr < DEPTH writes mem[load_addr] at the clock edge.
  - load_addr >= DEPTH: no write; load_err=1 next cycle.
  - start: pc<=0, state FETCH.
  - start and load_we in the same cycle: the write completes and FETCH is entered. A read of the same address one cycle later returns the new data.
- FETCH/DRAIN: load_we is ignored and raises load_err. start is ignored.
- FETCH, priority order:
  1. branch_valid: out_valid<=0 (flush); pc<=branch_target, clamped to DEPTH-1 if >= DEPTH; no fetch this cycle. A fire in the same cycle still counts as consumed.
  2. advance: out_instr<=mem[pc], out_pc<=pc, out_valid<=1. Then:
     - pc<DEPTH-1: pc<=pc+1.
     - pc==DEPTH-1 and CLAMP_LAST=1: pc holds, so the last word is reissued on every later advance.
     - pc==DEPTH-1 and CLAMP_LAST=0: state DRAIN, pc holds.
  3. Otherwise (stall: out_valid & ~out_ready): all output registers hold.
- DRAIN: branch_valid is honoured exactly as in FETCH, returning to FETCH. If out_valid becomes 0 or fire occurs, out_valid<=0 and state DONE.
- Latency: one cycle from the PC being presented to out_valid.
- Throughput: one instruction per cycle while out_ready=1.
- Outputs are stable while out_valid & ~out_ready.
- A reset mid-FETCH drops out_valid in the next cycle; no partial instruction is retained.

Decomposition:
- Package fetch_pkg: state enum {IDLE, FETCH, DRAIN, DONE}, localparam AW=$clog2(DEPTH), and a clamp function for the PC.
- Sub-module inst_store: DEPTH x IW array, synchronous write, combinational read. No reset on the array.
- The top level holds the FSM, PC and output register.

Test Plan:
1. Load mem[i]=16'hA000+i for i=0..23, start, out_ready=1 -> out_pc 0..23 on consecutive cycles with out_instr A000..A017. With CLAMP_LAST=1, A017/pc 23 then repeats indefinitely.
2. Same load with CLAMP_LAST=0 -> after pc 23 is accepted, out_valid=0, done=1, busy=0. A further start restarts from pc 0.
3. Backpressure: out_ready=0 for 3 cycles at pc 5 -> out_instr=A005 and out_pc=5 held for all 3 cycles. Resume gives pc 6 next with no skip or duplicate.
4. Branch: branch_valid with target 2 while out_pc=10 -> out_valid=0 next cycle, then pc 2,3,... Target 40 clamps to pc 23.
5. Load errors: load_we with addr 30 in IDLE -> load_err pulse, store unchanged. load_we during FETCH -> load_err pulse, store unchanged.
6. Reset asserted at pc 7 during FETCH -> next cycle out_valid=0, state IDLE, pc=0. Memory still reads A007 after a restart.
